par_calc_seq: RTL and testbench
===============================

PAR_CALC_SEQ -- requirements
Module: par_calc_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, legal range 5..16: maximum frame data width in bits.
REQ-002 SHALL have derived parameter LEN_W = clog2(DATA_WIDTH+1), not overridable: width of DATA_LEN.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, exactly as follows:
- CLK  in  1  single clock; all state changes on its rising edge.
- RST  in  1  asynchronous reset, active-high.
REQ-004 SHALL have the remaining ports:
- Data_Valid  in  1  request: capture P_DATA and configuration.
- P_DATA  in  DATA_WIDTH  parallel frame data; bit 0 transmitted first.
- DATA_LEN  in  LEN_W  active data bits.
- PAR_EN  in  1  1 = parity enabled, 0 = no parity.
- PAR_TYP  in  2  parity mode: 00 even, 01 odd, 10 mark (always 1), 11 space (always 0).
- PAR_Calc_en  in  1  consume strobe from the TX FSM; releases the result.
- CLR_ERR  in  1  clears OVERRUN.
- PAR_bit  out  1  registered parity result.
- PAR_Valid  out  1  PAR_bit is valid and held.
- Busy  out  1  high whenever state is not IDLE.
- OVERRUN  out  1  sticky flag: request dropped.

Function
REQ-005 SHALL implement three states, IDLE, CALC and DONE, with Busy = (state != IDLE), decoded from registered state.
REQ-006 In IDLE, on Data_Valid=1 the block SHALL capture P_DATA, the effective length, PAR_EN and PAR_TYP into internal registers, clear the accumulator and bit counter, and go to CALC.
REQ-007 Effective length SHALL be DATA_WIDTH when DATA_LEN is 0 or greater than DATA_WIDTH; otherwise it SHALL be DATA_LEN.
REQ-008 In CALC, each cycle SHALL XOR captured bit [counter] into the accumulator and increment the counter, processing exactly one bit per cycle, LSB first.
REQ-009 Bits at or above the effective length SHALL NOT affect the result.
REQ-010 After the last bit, the block SHALL load PAR_bit and go to DONE:
- even: accumulator.
- odd: inverted accumulator.
- mark: 1.
- space: 0.
REQ-011 Latency: PAR_Valid SHALL rise on the Nth rising edge after the capture edge, where N is the effective length.
REQ-012 If captured PAR_EN=0, the block SHALL skip CALC, go to DONE on the first edge after capture, and load PAR_bit=0.
REQ-013 In DONE, PAR_Valid=1, and PAR_bit SHALL hold stable until consumed.
REQ-014 PAR_Calc_en=1 in DONE SHALL deassert PAR_Valid on the same edge and return to IDLE.
REQ-015 PAR_Calc_en SHALL be ignored in IDLE and CALC.
REQ-016 Data_Valid=1 together with PAR_Calc_en=1 in DONE SHALL consume the current result and capture the new request on the same edge, going to CALC, or to DONE if the new PAR_EN=0.
REQ-017 Data_Valid=1 in CALC, or in DONE without PAR_Calc_en, SHALL be dropped without disturbing the calculation in progress, and SHALL set OVERRUN on that edge.
REQ-018 Changes on PAR_TYP, PAR_EN, DATA_LEN or P_DATA after capture SHALL have no effect on the calculation in progress.
REQ-019 OVERRUN SHALL clear on CLR_ERR=1.
REQ-020 CLR_ERR SHALL win over a simultaneous overrun event, so OVERRUN=0 after that edge.
REQ-021 PAR_bit SHALL retain its last value in IDLE and CALC.

Reset
REQ-022 RST=1 SHALL immediately, without waiting for a clock edge, force:
- state to IDLE;
- PAR_bit=0, PAR_Valid=0, Busy=0, OVERRUN=0;
- counter, accumulator and captured registers to 0.
REQ-023 Reset asserted mid-CALC or in DONE SHALL abort the operation.
REQ-024 After RST deasserts, the first Data_Valid SHALL be accepted normally.

Verification
REQ-025 Even parity, full length: DATA_WIDTH=8, P_DATA=8'hA5, DATA_LEN=8, PAR_EN=1, PAR_TYP=00, Data_Valid pulse -> Busy=1 next cycle; PAR_Valid=1 and PAR_bit=0 on the 8th edge after capture; PAR_Calc_en -> PAR_Valid=0, Busy=0.
REQ-026 Odd parity and short length:
- P_DATA=8'hA5, PAR_TYP=01 -> PAR_bit=1.
- P_DATA=8'hFF, DATA_LEN=5, PAR_TYP=00 -> PAR_bit=1 after 5 edges, upper bits ignored.
- DATA_LEN=0 or 12 -> treated as 8.
REQ-027 Fixed modes and parity disabled:
- PAR_TYP=10 with P_DATA=8'h00 -> PAR_bit=1.
- PAR_TYP=11 with P_DATA=8'hFF -> PAR_bit=0.
- PAR_EN=0 -> PAR_Valid on the 1st edge after capture, PAR_bit=0.
REQ-028 Overrun:
- Data_Valid during CALC -> original result unchanged, OVERRUN=1.
- CLR_ERR -> OVERRUN=0.
- Simultaneous CLR_ERR and new overrun -> OVERRUN=0.
REQ-029 Back-to-back and reset: Data_Valid with PAR_Calc_en in DONE -> new capture with no idle cycle; PAR_TYP toggled mid-CALC -> no effect; RST asserted mid-CALC without a clock edge -> all outputs 0 at once, then a normal operation after release.

Source files
------------

// File: rtl/par_calc_seq_if.sv
// Parity calculator bus: request/configuration from the TX FSM and the
// registered parity result returned by par_calc_seq.
//   master : drives Data_Valid, P_DATA, DATA_LEN, PAR_EN, PAR_TYP,
//            PAR_Calc_en, CLR_ERR; observes PAR_bit, PAR_Valid, Busy, OVERRUN
//   slave  : the calculator side (opposite directions)
interface par_calc_seq_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int LEN_W = $clog2(DATA_WIDTH + 1);

  logic                  Data_Valid;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic [LEN_W-1:0]      DATA_LEN;
  logic                  PAR_EN;
  logic [1:0]            PAR_TYP;
  logic                  PAR_Calc_en;
  logic                  CLR_ERR;
  logic                  PAR_bit;
  logic                  PAR_Valid;
  logic                  Busy;
  logic                  OVERRUN;

  modport master (
    output Data_Valid, P_DATA, DATA_LEN, PAR_EN, PAR_TYP, PAR_Calc_en, CLR_ERR,
    input  PAR_bit, PAR_Valid, Busy, OVERRUN
  );

  modport slave (
    input  Data_Valid, P_DATA, DATA_LEN, PAR_EN, PAR_TYP, PAR_Calc_en, CLR_ERR,
    output PAR_bit, PAR_Valid, Busy, OVERRUN
  );
endinterface

// File: rtl/par_calc_seq.sv
// Sequential parity calculator: captures a frame and its configuration,
// folds one data bit per clock (LSB first) into an XOR accumulator, then
// presents the parity bit until the TX FSM consumes it.
//   CLK  : clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : par_calc_seq_if slave (request, config, result, status)
module par_calc_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  par_calc_seq_if.slave  bus
);
  localparam int LEN_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_data;
  logic [LEN_W-1:0]      r_len;
  logic                  r_en;
  logic [1:0]            r_typ;
  logic [LEN_W-1:0]      r_cnt;
  logic                  r_acc;
  logic                  r_par_bit;
  logic                  r_overrun;

  logic                  w_capture;
  logic                  w_drop;
  logic                  w_last;
  logic [LEN_W-1:0]      w_eff_len;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic                  w_bit;
  logic                  w_acc_next;
  logic                  w_result;

  // Zero or oversize lengths fall back to the full frame width.
  always_comb begin
    w_eff_len = DATA_LEN_sel();
  end

  function automatic logic [LEN_W-1:0] DATA_LEN_sel();
    if (bus.DATA_LEN == '0 || bus.DATA_LEN > LEN_W'(DATA_WIDTH))
      return LEN_W'(DATA_WIDTH);
    else
      return bus.DATA_LEN;
  endfunction

  // Shift instead of a variable bit-select so the counter width need not
  // match the index width of r_data.
  always_comb begin
    w_shifted  = r_data >> r_cnt;
    w_bit      = w_shifted[0];
    w_acc_next = r_acc ^ w_bit;
    unique case (r_typ)
      2'b00:   w_result = w_acc_next;
      2'b01:   w_result = ~w_acc_next;
      2'b10:   w_result = 1'b1;
      default: w_result = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_drop    = 1'b0;
    w_last    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.Data_Valid) begin
          w_capture = 1'b1;
          w_next    = S_CALC;
        end
      end
      S_CALC: begin
        w_drop = bus.Data_Valid;
        // Parity disabled spends exactly one cycle here so PAR_Valid
        // rises on the first edge after capture.
        if (!r_en) begin
          w_next = S_DONE;
        end else if (r_cnt == r_len - LEN_W'(1)) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.PAR_Calc_en) begin
          if (bus.Data_Valid) begin
            w_capture = 1'b1;
            w_next    = S_CALC;
          end else begin
            w_next = S_IDLE;
          end
        end else begin
          w_drop = bus.Data_Valid;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_data    <= '0;
      r_len     <= '0;
      r_en      <= 1'b0;
      r_typ     <= '0;
      r_cnt     <= '0;
      r_acc     <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_capture) begin
      r_data <= bus.P_DATA;
      r_len  <= w_eff_len;
      r_en   <= bus.PAR_EN;
      r_typ  <= bus.PAR_TYP;
      r_cnt  <= '0;
      r_acc  <= 1'b0;
    end else if (r_state == S_CALC) begin
      if (!r_en) begin
        r_par_bit <= 1'b0;
      end else begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + LEN_W'(1);
        if (w_last) r_par_bit <= w_result;
      end
    end
  end

  // CLR_ERR has priority over a same-edge overrun.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)              r_overrun <= 1'b0;
    else if (bus.CLR_ERR) r_overrun <= 1'b0;
    else if (w_drop)      r_overrun <= 1'b1;
  end

  assign bus.PAR_bit   = r_par_bit;
  assign bus.PAR_Valid = (r_state == S_DONE);
  assign bus.Busy      = (r_state != S_IDLE);
  assign bus.OVERRUN   = r_overrun;
endmodule

// File: tb/tb_par_calc_seq.sv
module tb_par_calc_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  par_calc_seq_if #(.DATA_WIDTH(8)) bus ();

  par_calc_seq #(.DATA_WIDTH(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    logic       en;
    logic [1:0] typ;
    logic       exp_bit;
    int         exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic start(input logic [7:0] d, input logic [3:0] l,
                       input logic en, input logic [1:0] t);
    bus.P_DATA     = d;
    bus.DATA_LEN   = l;
    bus.PAR_EN     = en;
    bus.PAR_TYP    = t;
    bus.Data_Valid = 1'b1;
    tick();
    bus.Data_Valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.PAR_Valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    bus.PAR_Calc_en = 1'b1;
    tick();
    bus.PAR_Calc_en = 1'b0;
  endtask

  initial begin
    int lat;
    bus.Data_Valid  = 1'b0;
    bus.P_DATA      = '0;
    bus.DATA_LEN    = '0;
    bus.PAR_EN      = 1'b0;
    bus.PAR_TYP     = '0;
    bus.PAR_Calc_en = 1'b0;
    bus.CLR_ERR     = 1'b0;

    vecs[0] = '{8'hA5, 4'd8,  1'b1, 2'b00, 1'b0, 8};
    vecs[1] = '{8'hA5, 4'd8,  1'b1, 2'b01, 1'b1, 8};
    vecs[2] = '{8'hFF, 4'd5,  1'b1, 2'b00, 1'b1, 5};
    vecs[3] = '{8'h1F, 4'd0,  1'b1, 2'b00, 1'b1, 8};
    vecs[4] = '{8'h3F, 4'd12, 1'b1, 2'b00, 1'b0, 8};
    vecs[5] = '{8'h00, 4'd8,  1'b1, 2'b10, 1'b1, 8};
    vecs[6] = '{8'hFF, 4'd8,  1'b1, 2'b11, 1'b0, 8};
    vecs[7] = '{8'hFF, 4'd8,  1'b0, 2'b01, 1'b0, 1};
    vecs[8] = '{8'h01, 4'd1,  1'b1, 2'b00, 1'b1, 1};
    vecs[9] = '{8'h80, 4'd7,  1'b1, 2'b01, 1'b1, 7};

    // Reset state
    tick();
    tick();
    check("rst_busy",    int'(bus.Busy),      0);
    check("rst_valid",   int'(bus.PAR_Valid), 0);
    check("rst_bit",     int'(bus.PAR_bit),   0);
    check("rst_overrun", int'(bus.OVERRUN),   0);
    rst = 1'b0;
    tick();

    // Table-driven operations
    for (int i = 0; i < 10; i++) begin
      start(vecs[i].data, vecs[i].len, vecs[i].en, vecs[i].typ);
      check($sformatf("v%0d_busy", i), int'(bus.Busy), 1);
      wait_valid(lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_bit", i), int'(bus.PAR_bit), int'(vecs[i].exp_bit));
      tick();
      check($sformatf("v%0d_hold", i), int'(bus.PAR_Valid), 1);
      consume();
      check($sformatf("v%0d_cons_valid", i), int'(bus.PAR_Valid), 0);
      check($sformatf("v%0d_cons_busy", i), int'(bus.Busy), 0);
    end

    // Overrun during CALC, clear, and CLR_ERR priority
    start(8'hA5, 4'd8, 1'b1, 2'b00);
    tick();
    bus.P_DATA = 8'hFE; bus.PAR_TYP = 2'b01; bus.Data_Valid = 1'b1;
    tick();
    bus.Data_Valid = 1'b0;
    check("ovr_set", int'(bus.OVERRUN), 1);
    wait_valid(lat);
    check("ovr_lat", lat + 2, 8);
    check("ovr_bit", int'(bus.PAR_bit), 0);
    bus.CLR_ERR = 1'b1;
    tick();
    bus.CLR_ERR = 1'b0;
    check("ovr_clr", int'(bus.OVERRUN), 0);
    bus.CLR_ERR = 1'b1; bus.Data_Valid = 1'b1;
    tick();
    bus.CLR_ERR = 1'b0; bus.Data_Valid = 1'b0;
    check("ovr_clr_prio", int'(bus.OVERRUN), 0);
    check("ovr_done_kept", int'(bus.PAR_Valid), 1);
    check("ovr_done_bit", int'(bus.PAR_bit), 0);
    consume();

    // Back-to-back: consume and capture on the same edge
    start(8'hA5, 4'd8, 1'b1, 2'b01);
    wait_valid(lat);
    check("b2b_first_bit", int'(bus.PAR_bit), 1);
    bus.PAR_Calc_en = 1'b1;
    start(8'h03, 4'd2, 1'b1, 2'b00);
    bus.PAR_Calc_en = 1'b0;
    check("b2b_valid_low", int'(bus.PAR_Valid), 0);
    check("b2b_busy", int'(bus.Busy), 1);
    check("b2b_bit_held", int'(bus.PAR_bit), 1);
    wait_valid(lat);
    check("b2b_lat", lat, 2);
    check("b2b_bit", int'(bus.PAR_bit), 0);
    consume();

    // Inputs changed mid-CALC, PAR_Calc_en ignored in CALC
    start(8'hA5, 4'd8, 1'b1, 2'b00);
    bus.PAR_TYP = 2'b01; bus.P_DATA = 8'h01; bus.PAR_EN = 1'b0;
    bus.DATA_LEN = 4'd3; bus.PAR_Calc_en = 1'b1;
    tick();
    bus.PAR_Calc_en = 1'b0;
    wait_valid(lat);
    check("chg_lat", lat + 1, 8);
    check("chg_bit", int'(bus.PAR_bit), 0);
    consume();

    // Asynchronous reset mid-CALC
    start(8'hA5, 4'd8, 1'b1, 2'b01);
    wait_valid(lat);
    consume();
    check("pre_rst_bit", int'(bus.PAR_bit), 1);
    start(8'hA5, 4'd8, 1'b1, 2'b00);
    bus.Data_Valid = 1'b1;
    tick();
    bus.Data_Valid = 1'b0;
    check("pre_rst_ovr", int'(bus.OVERRUN), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",    int'(bus.Busy),      0);
    check("arst_valid",   int'(bus.PAR_Valid), 0);
    check("arst_bit",     int'(bus.PAR_bit),   0);
    check("arst_overrun", int'(bus.OVERRUN),   0);
    tick();
    rst = 1'b0;
    tick();
    start(8'hA5, 4'd8, 1'b1, 2'b01);
    wait_valid(lat);
    check("post_rst_lat", lat, 8);
    check("post_rst_bit", int'(bus.PAR_bit), 1);
    consume();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
